dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Responder side of the core's data-memory request interface; replaces the always-miss temporary memory behind the memory stage.
- Direct-mapped, write-through, no-write-allocate data cache. Answers read/write requests with ready/miss.
- On a read miss, refills a line from main memory over a simple req/gnt + beat interface.

Parameters:
- INDEX_BITS, 8, log2 of line count (256 lines).
- OFFSET_BITS, 2, log2 of words per line (4 words = 16 B).
- TAG_BITS, 32-INDEX_BITS-OFFSET_BITS-2, derived; not overridable.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; asynchronous, active-low.
- addr  in  32  byte address; word-aligned, addr[1:0] ignored.
- data_in  in  32  write data.
- write_enable  in  1  write request; sampled only when ready=1.
- read_enable  in  1  read request; sampled only when ready=1.
- data_out  out  32  read data.
- ready  out  1  1 = a request may be issued this cycle.
- miss  out  1  1 = core must stall; 0 = previous request complete.
- mem_req  out  1  downstream request, held until mem_gnt.
- mem_we  out  1  1 = write word, 0 = line read.
- mem_addr  out  32  word address for writes; line-aligned address for reads.
- mem_wdata  out  32  write data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read beat valid.
- mem_rdata  in  32  read beat data; beats arrive in offset order 0..3.

Behaviour:
- Reset (async): all valid bits cleared, FSM=IDLE, ready=1, miss=0, data_out=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0. Tag/data RAM contents are don't-care.
- FSM states: IDLE, COMPARE, REFILL_REQ, REFILL_DATA, RESPOND, WRITE_REQ.
- IDLE: ready=1, miss=0. A request latches addr/data/op and the arrays are read; next state is COMPARE. If both enables are high, the request is treated as a write.
- COMPARE: hit = valid[idx] && tag match; miss is combinational from registered state.
  - Read hit: miss=0, data_out = RAM word (latency 1 cycle), ready=1. A new request is accepted in the same cycle (back-to-back hits at 1/cycle).
  - Read miss: miss=1, ready=0, go to REFILL_REQ.
  - Write (hit or miss): a hit updates the cached word in this cycle; a miss leaves the cache untouched. miss=1, ready=0, go to WRITE_REQ.
- REFILL_REQ: mem_req=1, mem_we=0, mem_addr={tag,idx,OFFSET zeros,2'b00}. Go to REFILL_DATA on mem_gnt.
- REFILL_DATA:
  - Each mem_rvalid writes the beat to data[idx][beat]; the beat counter wraps at 2^OFFSET_BITS.
  - The beat whose index equals the request offset is captured into a holding register.
  - After the last beat: set tag and valid, go to RESPOND.
- RESPOND: miss=0, data_out = captured word, ready=1. A new request may be accepted; go to COMPARE or IDLE.
- WRITE_REQ: mem_req=1, mem_we=1, mem_addr={addr[31:2],2'b00}, mem_wdata=data_in. On mem_gnt go to IDLE; miss=0 from the next cycle.
- data_out holds the last completed read value until the next read completes; writes never change it.
- miss=1 is held across every stall cycle. ready=0 whenever miss=1.
- Requests issued while ready=0 are ignored.
- mem_req, once raised, stays high with stable mem_addr/mem_we/mem_wdata until mem_gnt.
- mem_rvalid outside REFILL_DATA is ignored.
- Reset mid-refill: the line stays invalid and no partial valid bit is set.

Optional Feature:
- Macro: DCACHE_WRITE_BUFFER_EN. Adds a one-entry posted write buffer.
- With the macro:
  - A write in COMPARE with the buffer empty is captured into the buffer: miss=0, ready=1, no stall.
  - The buffer drains via mem_req/mem_we=1 whenever the FSM is not using the port.
  - A write arriving with the buffer full stalls (miss=1) until the buffer drains.
  - A read miss waits for the buffer to drain before REFILL_REQ (keeps memory ordering, avoids a stale refill).
- Without the macro: behaviour exactly as in Behaviour (WRITE_REQ stall per write).

Decomposition:
- Package dcache_pkg: state enum, INDEX_BITS/OFFSET_BITS/TAG_BITS localparams, and tag/index/offset field-extract functions.
- One sub-module, dcache_data_ram: single-port synchronous word RAM with 2^(INDEX_BITS+OFFSET_BITS) entries, 1-cycle read, inferred as BRAM.
- Tags go in a small separate RAM or flop array inside the top. Valid bits are flops with async clear.

Test Plan:
1. After reset, read 0x0000_1004 with memory returning beats 0xA0,0xA1,0xA2,0xA3 -> miss=1 until RESPOND; data_out=0xA1 with miss=0; exactly one mem_req with mem_addr=0x0000_1000.
2. Read 0x1008 the cycle after scenario 1's RESPOND, then 0x100C back-to-back -> both hits; data_out=0xA2 then 0xA3 on consecutive cycles; miss never asserted; no mem_req.
3. Write 0xDEAD_BEEF to 0x1004 (hit), then read 0x1004 -> mem_req with mem_we=1, mem_addr=0x1004, wdata=0xDEADBEEF; read hits and returns 0xDEADBEEF.
4. Write 0x55 to 0x8000 (miss), then read 0x8000 -> write forwarded with no allocation; the read misses and refills from memory.
5. Read 0x1004, then read 0x5004 (same index, different tag), then 0x1004 again -> three refills (eviction verified); data_out matches each line's memory contents.
6. Assert rstn=0 during REFILL_DATA after 2 beats, release, read the same address -> miss=0/ready=1 immediately after reset; the read performs a full fresh refill.

Source files
------------

// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared geometry, FSM state type and address field helpers for the data cache.
package dcache_pkg;

  localparam int INDEX_BITS  = 8;
  localparam int OFFSET_BITS = 2;
  localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS - 2;
  localparam int LINES       = 1 << INDEX_BITS;
  localparam int WORDS       = 1 << OFFSET_BITS;
  localparam int RAM_AW      = INDEX_BITS + OFFSET_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_REFILL_REQ,
    S_REFILL_DATA,
    S_RESPOND,
    S_WRITE_REQ
  } state_e;

  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [31:0] a);
    return a[31 -: TAG_BITS];
  endfunction

  function automatic logic [INDEX_BITS-1:0] addr_index(input logic [31:0] a);
    return a[OFFSET_BITS+2 +: INDEX_BITS];
  endfunction

  function automatic logic [OFFSET_BITS-1:0] addr_offset(input logic [31:0] a);
    return a[2 +: OFFSET_BITS];
  endfunction

endpackage

// File: rtl/dcache_data_ram.sv
// rtl/dcache_data_ram.sv - single-port synchronous word RAM holding every cached line.
module dcache_data_ram
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              we_i,
  input  logic [RAM_AW-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] ram_q [1 << RAM_AW];
  logic [31:0] rdata_q;

  // Read-first: a write cycle returns the old word, which callers never consume.
  always_ff @(posedge clk) begin
    if (we_i) begin
      ram_q[addr_i] <= wdata_i;
    end
    rdata_q <= ram_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-through no-write-allocate data cache with line refill.
// Optional DCACHE_WRITE_BUFFER_EN adds a one-entry posted write buffer.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  input  logic        write_enable,
  input  logic        read_enable,
  output logic [31:0] data_out,
  output logic        ready,
  output logic        miss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  state_e                 state_q, state_d;
  logic [31:2]            req_addr_q;
  logic [31:0]            req_wdata_q;
  logic                   req_we_q;
  logic [LINES-1:0]       valid_q;
  logic [TAG_BITS-1:0]    tag_q [LINES];
  logic [OFFSET_BITS-1:0] beat_q;
  logic [31:0]            hold_q;
  logic [31:0]            data_out_q;

  logic [31:0]            req_word;
  logic [TAG_BITS-1:0]    req_tag;
  logic [INDEX_BITS-1:0]  req_idx;
  logic [OFFSET_BITS-1:0] req_off;
  logic                   req_valid;
  logic                   hit;
  logic                   buf_busy;
  logic                   ram_we;
  logic [RAM_AW-1:0]      ram_addr;
  logic [31:0]            ram_wdata;
  logic [31:0]            ram_rdata;
  logic                   unused_addr_lsbs;

  assign req_word  = {req_addr_q, 2'b00};
  assign req_tag   = addr_tag(req_word);
  assign req_idx   = addr_index(req_word);
  assign req_off   = addr_offset(req_word);
  assign req_valid = read_enable || write_enable;
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_addr_lsbs = ^addr[1:0];

`ifdef DCACHE_WRITE_BUFFER_EN
  logic        buf_valid_q;
  logic [31:0] buf_addr_q;
  logic [31:0] buf_data_q;
  logic        stale_q, stale_d;
  logic        wr_capture;

  assign buf_busy = buf_valid_q;

  // A write-hit update steals the RAM port, so a request accepted that cycle must re-read.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      stale_q     <= 1'b0;
    end else begin
      stale_q <= stale_d;
      if (wr_capture) begin
        buf_valid_q <= 1'b1;
        buf_addr_q  <= req_word;
        buf_data_q  <= req_wdata_q;
      end else if (buf_valid_q && mem_gnt) begin
        buf_valid_q <= 1'b0;
      end
    end
  end
`else
  assign buf_busy = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ready     = 1'b0;
    miss      = 1'b0;
    data_out  = data_out_q;
    ram_we    = 1'b0;
    ram_addr  = {addr_index(addr), addr_offset(addr)};
    ram_wdata = req_wdata_q;
`ifdef DCACHE_WRITE_BUFFER_EN
    stale_d    = 1'b0;
    wr_capture = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (req_valid) state_d = S_COMPARE;
      end
      S_COMPARE: begin
`ifdef DCACHE_WRITE_BUFFER_EN
        if (!req_we_q && stale_q) begin
          miss     = 1'b1;
          ram_addr = {req_idx, req_off};
        end else
`endif
        if (!req_we_q) begin
          if (hit) begin
            ready    = 1'b1;
            data_out = ram_rdata;
            state_d  = req_valid ? S_COMPARE : S_IDLE;
          end else begin
            miss    = 1'b1;
            state_d = S_REFILL_REQ;
          end
        end else begin
`ifdef DCACHE_WRITE_BUFFER_EN
          if (!buf_valid_q) begin
            wr_capture = 1'b1;
            ready      = 1'b1;
            ram_we     = hit;
            if (hit) ram_addr = {req_idx, req_off};
            stale_d    = hit && req_valid;
            state_d    = req_valid ? S_COMPARE : S_IDLE;
          end else begin
            miss = 1'b1;
          end
`else
          miss     = 1'b1;
          ram_we   = hit;
          ram_addr = {req_idx, req_off};
          state_d  = S_WRITE_REQ;
`endif
        end
      end
      S_REFILL_REQ: begin
        miss = 1'b1;
        if (mem_gnt && !buf_busy) state_d = S_REFILL_DATA;
      end
      S_REFILL_DATA: begin
        miss = 1'b1;
        if (mem_rvalid) begin
          ram_we    = 1'b1;
          ram_addr  = {req_idx, beat_q};
          ram_wdata = mem_rdata;
          if (beat_q == '1) state_d = S_RESPOND;
        end
      end
      S_RESPOND: begin
        ready    = 1'b1;
        data_out = hold_q;
        state_d  = req_valid ? S_COMPARE : S_IDLE;
      end
      S_WRITE_REQ: begin
        miss = 1'b1;
        if (mem_gnt) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pending buffered write owns the port first so a refill never reads stale memory.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
`ifdef DCACHE_WRITE_BUFFER_EN
    if (buf_valid_q) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = buf_addr_q;
      mem_wdata = buf_data_q;
    end else if (state_q == S_REFILL_REQ) begin
      mem_req  = 1'b1;
      mem_addr = {req_tag, req_idx, {OFFSET_BITS{1'b0}}, 2'b00};
    end
`else
    if (state_q == S_REFILL_REQ) begin
      mem_req  = 1'b1;
      mem_addr = {req_tag, req_idx, {OFFSET_BITS{1'b0}}, 2'b00};
    end else if (state_q == S_WRITE_REQ) begin
      mem_req   = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = req_word;
      mem_wdata = req_wdata_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_we_q    <= 1'b0;
      valid_q     <= '0;
      beat_q      <= '0;
      hold_q      <= '0;
      data_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      data_out_q <= data_out;
      if (ready && req_valid) begin
        req_addr_q  <= addr[31:2];
        req_wdata_q <= data_in;
        req_we_q    <= write_enable;
      end
      if (state_q == S_REFILL_REQ) begin
        beat_q <= '0;
      end
      if (state_q == S_REFILL_DATA && mem_rvalid) begin
        beat_q <= beat_q + 1'b1;
        if (beat_q == req_off) hold_q <= mem_rdata;
        if (beat_q == '1) valid_q[req_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_REFILL_DATA && mem_rvalid && beat_q == '1) begin
      tag_q[req_idx] <= req_tag;
    end
  end

  dcache_data_ram u_data_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - scoreboard bench for dcache_controller with a randomized memory responder.
module tb_dcache_controller;
  import dcache_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] addr, data_in, data_out, mem_addr, mem_wdata, mem_rdata;
  logic        write_enable, read_enable, ready, miss;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk          (clk),
    .rstn         (rstn),
    .addr         (addr),
    .data_in      (data_in),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .data_out     (data_out),
    .ready        (ready),
    .miss         (miss),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  typedef struct { bit we; logic [31:0] addr; logic [31:0] data; } op_t;

  op_t         ops[$];
  op_t         sb[$];
  op_t         txlog[$];
  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] ref_m [logic [31:0]];
  logic [31:0] last_rd;
  int          n_checks = 0;
  int          n_pass = 0;
  int          beats_sent = 0;
  int          beats_left = 0;
  int          beat_idx = 0;
  logic [31:0] rd_line;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_m.exists(a) ? ref_m[a] : dflt(a);
  endfunction

  task automatic rd(input logic [31:0] a);
    ops.push_back('{1'b0, a, 32'h0});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ops.push_back('{1'b1, a, d});
  endtask

  task automatic chk_txn(input string tag, input int idx, input bit we, input logic [31:0] a,
                         input logic [31:0] d);
    if (idx < txlog.size()) begin
      check({tag, "_we"}, {31'b0, txlog[idx].we}, {31'b0, we});
      check({tag, "_addr"}, txlog[idx].addr, a);
      if (we) check({tag, "_wdata"}, txlog[idx].data, d);
    end else begin
      check({tag, "_present"}, txlog.size(), idx + 1);
    end
  endtask

  // Memory side: random grant delay, beats with random gaps, writes land at grant.
  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (!rstn) begin
        beats_left = 0;
      end else if (beats_left > 0) begin
        if ($urandom_range(0, 3) != 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_rd(rd_line + 32'(beat_idx * 4));
          beat_idx++;
          beats_left--;
          beats_sent++;
        end
      end else if (mem_req && $urandom_range(0, 1) == 1) begin
        mem_gnt = 1'b1;
        txlog.push_back('{mem_we, mem_addr, mem_wdata});
        if (mem_we) mem_m[mem_addr] = mem_wdata;
        else begin rd_line = mem_addr; beat_idx = 0; beats_left = WORDS; end
      end
    end
  end

  // Core side: issue when ready, complete on the first cycle with miss low.
  task automatic run_ops(input string name, output int stalls);
    int  cyc = 0;
    bit  pend = 0;
    bit  viol = 0;
    op_t op, e;
    stalls = 0;
    while ((ops.size() > 0 || pend) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (miss && ready) viol = 1;
      if (pend) begin
        if (!miss) begin
          e = sb.pop_front();
          pend = 0;
          if (!e.we) begin
            check($sformatf("%s_rd_%h", name, e.addr), data_out, e.data);
            last_rd = e.data;
          end else begin
            check($sformatf("%s_wr_hold_%h", name, e.addr), data_out, last_rd);
          end
        end else begin
          stalls++;
        end
      end
      if (!pend && ready && ops.size() > 0) begin
        op = ops.pop_front();
        addr = op.addr; data_in = op.data;
        write_enable = op.we; read_enable = !op.we;
        if (op.we) begin
          ref_m[{op.addr[31:2], 2'b00}] = op.data;
          sb.push_back(op);
        end else begin
          sb.push_back('{1'b0, op.addr, ref_rd({op.addr[31:2], 2'b00})});
        end
        pend = 1;
      end else begin
        write_enable = 1'b0; read_enable = 1'b0;
      end
    end
    write_enable = 1'b0; read_enable = 1'b0;
    check({name, "_done"}, ops.size() + 32'(pend), 0);
    check({name, "_miss_ready_excl"}, {31'b0, viol}, 0);
  endtask

  initial begin
    int st;
    int b0;
    int n;
    rstn = 1'b0; addr = '0; data_in = '0; write_enable = 1'b0; read_enable = 1'b0;
    last_rd = '0;
    for (int i = 0; i < 4; i++) begin
      mem_m[32'h1000 + 32'(4 * i)] = 32'hA0 + 32'(i);
      ref_m[32'h1000 + 32'(4 * i)] = 32'hA0 + 32'(i);
    end
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'b0, ready}, 1);
    check("rst_miss", {31'b0, miss}, 0);
    check("rst_data_out", data_out, 0);
    check("rst_mem_req", {31'b0, mem_req}, 0);
    check("rst_mem_we", {31'b0, mem_we}, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);

    txlog.delete(); rd(32'h1004);
    run_ops("t1", st);
    check("t1_stalled", {31'b0, st > 0}, 1);
    check("t1_nreq", txlog.size(), 1);
    chk_txn("t1_req", 0, 1'b0, 32'h1000, 0);

    txlog.delete(); rd(32'h1008); rd(32'h100C);
    run_ops("t2", st);
    check("t2_stalls", st, 0);
    check("t2_nreq", txlog.size(), 0);

    txlog.delete(); wr(32'h1004, 32'hDEAD_BEEF); rd(32'h1004);
    run_ops("t3", st);
    check("t3_nreq", txlog.size(), 1);
    chk_txn("t3_wr", 0, 1'b1, 32'h1004, 32'hDEAD_BEEF);

    txlog.delete(); wr(32'h8000, 32'h55); rd(32'h8000);
    run_ops("t4", st);
    check("t4_nreq", txlog.size(), 2);
    chk_txn("t4_wr", 0, 1'b1, 32'h8000, 32'h55);
    chk_txn("t4_refill", 1, 1'b0, 32'h8000, 0);

    txlog.delete(); rd(32'h1004); rd(32'h5004); rd(32'h1004);
    run_ops("t5", st);
    check("t5_nreq", txlog.size(), 3);
    chk_txn("t5_refill0", 0, 1'b0, 32'h1000, 0);
    chk_txn("t5_refill1", 1, 1'b0, 32'h5000, 0);
    chk_txn("t5_refill2", 2, 1'b0, 32'h1000, 0);

    n = 0;
    @(negedge clk);
    while (!ready && n < 100) begin @(negedge clk); n++; end
    b0 = beats_sent;
    addr = 32'h2008; read_enable = 1'b1;
    @(negedge clk);
    read_enable = 1'b0;
    n = 0;
    while (beats_sent < b0 + 2 && n < 200) begin @(posedge clk); n++; end
    check("t6_two_beats", beats_sent - b0, 2);
    #1 rstn = 1'b0;
    @(negedge clk);
    check("t6_rst_miss", {31'b0, miss}, 0);
    check("t6_rst_ready", {31'b0, ready}, 1);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    sb.delete(); last_rd = '0;
    @(negedge clk);
    check("t6_post_ready", {31'b0, ready}, 1);
    check("t6_post_mem_req", {31'b0, mem_req}, 0);
    check("t6_post_data_out", data_out, 0);
    txlog.delete(); rd(32'h2008);
    run_ops("t6", st);
    check("t6_nreq", txlog.size(), 1);
    chk_txn("t6_refill", 0, 1'b0, 32'h2000, 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
